hr_interval_bpm: RTL and testbench



---
 rtl/hr_interval_bpm.sv | 171 +++++++++++++++++
 tb/tb_hr_interval_bpm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hr_interval_bpm.sv
// Beat-interval measurement with a 4-deep interval history and restoring-divider BPM output.
// Optional outlier rejection against the running average: define HR_OUTLIER_REJECT_EN.
module hr_interval_bpm #(
  parameter int SAMPLE_RATE  = 100,
  parameter int CNT_W        = 11,
  parameter int MIN_INTERVAL = 30,
  parameter int MAX_INTERVAL = 200
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             sample_tick,
  input  logic             peak,
  output logic [CNT_W-1:0] interval,
  output logic             beat_accepted,
  output logic             beat_rejected,
  output logic             locked,
  output logic [7:0]       bpm,
  output logic             bpm_valid
);

  localparam int SUM_W = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_INTERVAL + 1);
  localparam logic [CNT_W-1:0] CNT_MIN  = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [15:0]      DIVIDEND = 16'(60 * SAMPLE_RATE * 4);

  typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;
  state_t state, state_next;

  logic [CNT_W-1:0] cnt;
  logic             armed;
  logic             pending;
  logic [CNT_W-1:0] history [4];
  logic [1:0]       wr_ptr;
  logic [SUM_W-1:0] sum;
  logic [2:0]       fill;
  logic [15:0]      quot;
  logic [SUM_W-1:0] rem;
  logic [SUM_W-1:0] divisor;
  logic [3:0]       div_cnt;
  logic [SUM_W:0]   rem_shift;
  logic             rem_ge;

  logic timeout, in_range, outlier, restart, accept, reject;

`ifdef HR_OUTLIER_REJECT_EN
  logic [SUM_W-1:0] avg, cnt_ext, dev;
  always_comb begin
    avg     = sum >> 2;
    cnt_ext = SUM_W'(cnt);
    dev     = (cnt_ext > avg) ? (cnt_ext - avg) : (avg - cnt_ext);
    outlier = locked && (dev > (sum >> 4));
  end
`else
  assign outlier = 1'b0;
`endif

  assign locked   = (fill == 3'd4);
  assign timeout  = armed && (cnt == CNT_SAT);
  assign in_range = (cnt >= CNT_MIN);
  // Any in-range peak restarts the counter, even one rejected as an outlier.
  assign restart  = peak && armed && !timeout && in_range;
  assign accept   = restart && !outlier;
  assign reject   = peak && armed && !timeout && !accept;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      armed <= 1'b0;
    end else if (peak && (!armed || timeout)) begin
      cnt   <= '0;
      armed <= 1'b1;
    end else if (timeout) begin
      armed <= 1'b0;
    end else if (restart) begin
      cnt <= sample_tick ? CNT_ONE : '0;
    end else if (sample_tick && (cnt != CNT_SAT)) begin
      cnt <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      interval      <= '0;
      beat_accepted <= 1'b0;
      beat_rejected <= 1'b0;
    end else begin
      beat_accepted <= accept;
      beat_rejected <= reject;
      if (accept || reject) interval <= cnt;
    end
  end

  // Slots not yet filled hold zero, so subtracting the oldest entry is always safe.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) history[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
    end else if (timeout) begin
      for (int i = 0; i < 4; i++) history[i] <= '0;
      wr_ptr <= '0;
      sum    <= '0;
      fill   <= '0;
    end else if (accept) begin
      history[wr_ptr] <= cnt;
      wr_ptr          <= wr_ptr + 2'd1;
      sum             <= sum - SUM_W'(history[wr_ptr]) + SUM_W'(cnt);
      if (fill != 3'd4) fill <= fill + 3'd1;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && (fill >= 3'd3)) state_next = LOAD;
      LOAD:    state_next = DIV;
      DIV:     if (div_cnt == 4'd15) state_next = DONE;
      DONE:    state_next = (pending || accept) ? LOAD : IDLE;
      default: state_next = IDLE;
    endcase
    if (timeout) state_next = IDLE;
  end

  assign rem_shift = {rem, quot[15]};
  assign rem_ge    = (rem_shift >= {1'b0, divisor});

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      pending   <= 1'b0;
      quot      <= '0;
      rem       <= '0;
      divisor   <= '0;
      div_cnt   <= '0;
      bpm       <= '0;
      bpm_valid <= 1'b0;
    end else begin
      state     <= state_next;
      bpm_valid <= 1'b0;
      if (timeout) begin
        pending   <= 1'b0;
        bpm       <= '0;
        bpm_valid <= 1'b1;
      end else begin
        if (accept && ((state == LOAD) || (state == DIV))) pending <= 1'b1;
        case (state)
          LOAD: begin
            quot    <= DIVIDEND;
            rem     <= '0;
            divisor <= sum;
            div_cnt <= '0;
          end
          DIV: begin
            quot    <= {quot[14:0], rem_ge};
            rem     <= rem_ge ? SUM_W'(rem_shift - {1'b0, divisor}) : SUM_W'(rem_shift);
            div_cnt <= div_cnt + 4'd1;
          end
          DONE: begin
            bpm       <= (|quot[15:8]) ? 8'hFF : quot[7:0];
            bpm_valid <= 1'b1;
            pending   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hr_interval_bpm.sv
// Directed bench for hr_interval_bpm: a reference model of beats, history and divide timing
// is checked every cycle, alongside hand-computed BPM values and pulse expectations.
module tb_hr_interval_bpm;

  localparam int MIN_INT = 30;
  localparam int MAX_INT = 200;
  localparam int DIVD    = 24000;

  logic        clock;
  logic        reset_n;
  logic        sample_tick;
  logic        peak;
  logic [10:0] interval;
  logic        beat_accepted;
  logic        beat_rejected;
  logic        locked;
  logic [7:0]  bpm;
  logic        bpm_valid;

  hr_interval_bpm dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sample_tick   (sample_tick),
    .peak          (peak),
    .interval      (interval),
    .beat_accepted (beat_accepted),
    .beat_rejected (beat_rejected),
    .locked        (locked),
    .bpm           (bpm),
    .bpm_valid     (bpm_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int asserts    = 0;
  int failures   = 0;
  int cyc        = 0;
  int since_peak = 0;
  int valid_seen = 0;

  // Reference model state: accepted intervals oldest-first, divide completion edge.
  int m_hist[$];
  int m_cnt, m_interval, m_bpm, m_edge, m_done_at, m_div_sum, m_sum, m_dev;
  bit m_armed, m_acc, m_rej, m_valid, m_busy, m_pending, m_timeout, m_good;

  function automatic int hist_sum();
    int s = 0;
    foreach (m_hist[i]) s += m_hist[i];
    return s;
  endfunction

  function automatic int bpm_of(input int s);
    return (DIVD / s > 255) ? 255 : DIVD / s;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_hist.delete();
      m_cnt = 0; m_interval = 0; m_bpm = 0; m_edge = 0; m_done_at = 0; m_div_sum = 0;
      m_armed = 0; m_acc = 0; m_rej = 0; m_valid = 0; m_busy = 0; m_pending = 0;
    end else begin
      m_edge++;
      m_acc = 0; m_rej = 0; m_valid = 0;
      m_sum = hist_sum();
      m_timeout = m_armed && (m_cnt == MAX_INT + 1);
      if (m_timeout) begin
        m_hist.delete();
        m_busy = 0; m_pending = 0; m_bpm = 0; m_valid = 1;
        m_armed = peak;
        if (peak) m_cnt = 0;
      end else if (peak && !m_armed) begin
        m_armed = 1;
        m_cnt = 0;
      end else if (peak) begin
        m_interval = m_cnt;
        m_good = (m_cnt >= MIN_INT);
`ifdef HR_OUTLIER_REJECT_EN
        if (m_good && m_hist.size() == 4) begin
          m_dev = m_cnt - m_sum / 4;
          if (m_dev < 0) m_dev = -m_dev;
          if (m_dev > m_sum / 16) m_good = 0;
        end
`endif
        if (m_good) begin
          m_acc = 1;
          m_hist.push_back(m_cnt);
          if (m_hist.size() > 4) void'(m_hist.pop_front());
        end else begin
          m_rej = 1;
        end
        if (m_cnt >= MIN_INT) m_cnt = sample_tick ? 1 : 0;
        else if (sample_tick) m_cnt++;
      end else if (sample_tick && m_cnt <= MAX_INT) begin
        m_cnt++;
      end
      // A divide finishes 18 edges after it is requested and uses the sum current at request.
      if (!m_timeout) begin
        if (m_busy && m_edge == m_done_at) begin
          m_bpm = bpm_of(m_div_sum);
          m_valid = 1;
          m_busy = 0;
          if (m_pending || m_acc) begin
            m_div_sum = hist_sum(); m_done_at = m_edge + 18; m_busy = 1; m_pending = 0;
          end
        end else if (m_acc) begin
          if (m_busy) m_pending = 1;
          else if (m_hist.size() == 4) begin
            m_div_sum = hist_sum(); m_done_at = m_edge + 18; m_busy = 1;
          end
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] act, input int exp);
    asserts++;
    if (act !== 16'(exp)) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    checkOutput("interval", 16'(interval), m_interval);
    checkOutput("beat_accepted", 16'(beat_accepted), int'(m_acc));
    checkOutput("beat_rejected", 16'(beat_rejected), int'(m_rej));
    checkOutput("locked", 16'(locked), int'(m_hist.size() == 4));
    checkOutput("bpm", 16'(bpm), m_bpm);
    checkOutput("bpm_valid", 16'(bpm_valid), int'(m_valid));
  end

  task automatic applyStimulus(input logic pk);
    @(negedge clock);
    peak = pk;
    sample_tick = (cyc % 4 == 0);
    cyc++;
    since_peak = pk ? 0 : since_peak + 1;
    if (bpm_valid) valid_seen++;
  endtask

  task automatic peak_after(input int ticks);
    while (since_peak < ticks * 4 - 1) applyStimulus(1'b0);
    applyStimulus(1'b1);
  endtask

  task automatic arm();
    while (cyc % 4 != 2) applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkOutput("arm_no_accept", 16'(beat_accepted), 0);
    checkOutput("arm_no_reject", 16'(beat_rejected), 0);
  endtask

  task automatic accept_peak(input int ticks, input int exp_interval);
    peak_after(ticks);
    applyStimulus(1'b0);
    checkOutput("accept_pulse", 16'(beat_accepted), 1);
    checkOutput("accept_interval", 16'(interval), exp_interval);
  endtask

  task automatic wait_bpm(input string name, input int exp);
    int n = 0;
    while (!bpm_valid && n < 40) begin
      applyStimulus(1'b0);
      n++;
    end
    checkOutput({name, "_latency"}, 16'(n), 18);
    checkOutput(name, 16'(bpm), exp);
  endtask

  int exp_lock60[4] = '{84, 88, 94, 100};
  int exp_back75[3] = '{88, 84, 80};

  initial begin
    reset_n = 1'b1;
    peak = 1'b0;
    sample_tick = 1'b0;
    #1 reset_n = 1'b0;
    repeat (3) applyStimulus(1'b0);
    checkOutput("reset_bpm", 16'(bpm), 0);
    checkOutput("reset_locked", 16'(locked), 0);
    checkOutput("reset_interval", 16'(interval), 0);
    #2 reset_n = 1'b1;

    // Lock at 75-tick intervals: 24000/300 = 80.
    arm();
    for (int i = 0; i < 3; i++) accept_peak(75, 75);
    checkOutput("locked_after_3", 16'(locked), 0);
    accept_peak(75, 75);
    wait_bpm("bpm_80", 80);
    checkOutput("locked_after_4", 16'(locked), 1);

    // Faster rhythm: sums 285, 270, 255, 240.
    for (int i = 0; i < 4; i++) begin
      accept_peak(60, 60);
      wait_bpm("bpm_60_seq", exp_lock60[i]);
    end

    // Notch pulse 20 ticks in is dropped without restarting the interval.
    peak_after(20);
    applyStimulus(1'b0);
    checkOutput("notch_reject", 16'(beat_rejected), 1);
    checkOutput("notch_interval", 16'(interval), 20);
    accept_peak(55, 75);
    wait_bpm("bpm_after_notch", 94);

    for (int i = 0; i < 3; i++) begin
      accept_peak(75, 75);
      wait_bpm("bpm_back_75", exp_back75[i]);
    end

    // Interval 100 against an average of 75.
    peak_after(100);
    applyStimulus(1'b0);
    checkOutput("long_interval", 16'(interval), 100);
`ifdef HR_OUTLIER_REJECT_EN
    checkOutput("outlier_reject", 16'(beat_rejected), 1);
    valid_seen = 0;
    repeat (30) applyStimulus(1'b0);
    checkOutput("outlier_no_valid", 16'(valid_seen), 0);
    checkOutput("outlier_bpm_kept", 16'(bpm), 80);
`else
    checkOutput("long_accept", 16'(beat_accepted), 1);
    wait_bpm("bpm_325", 73);
`endif

    // Silence past MAX_INTERVAL ticks drops lock with a single bpm=0 report.
    valid_seen = 0;
    repeat (840) applyStimulus(1'b0);
    checkOutput("timeout_valid_count", 16'(valid_seen), 1);
    checkOutput("timeout_locked", 16'(locked), 0);
    checkOutput("timeout_bpm", 16'(bpm), 0);
    arm();

    // Relock, then reset five cycles into the divide.
    for (int i = 0; i < 4; i++) accept_peak(75, 75);
    repeat (6) applyStimulus(1'b0);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("midreset_locked", 16'(locked), 0);
    checkOutput("midreset_bpm", 16'(bpm), 0);
    checkOutput("midreset_interval", 16'(interval), 0);
    checkOutput("midreset_valid", 16'(bpm_valid), 0);
    repeat (5) applyStimulus(1'b0);
    #2 reset_n = 1'b1;
    valid_seen = 0;
    arm();
    for (int i = 0; i < 3; i++) accept_peak(75, 75);
    checkOutput("postreset_no_valid", 16'(valid_seen), 0);
    checkOutput("postreset_unlocked", 16'(locked), 0);
    accept_peak(75, 75);
    wait_bpm("postreset_bpm", 80);
    repeat (4) applyStimulus(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
